image_loader: RTL

IMAGE_LOADER -- requirements
Module: image_loader

---
 rtl/image_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/image_loader.sv
// -----------------------------------------------------------------------------
// image_loader
//
// Streams NUM_PIXELS bytes from a valid/ready source into the data RAM. Each
// byte is zero-extended and written to BASE_ADDR + index. While a load is in
// progress the processor's memory-stage write port is held off. In every other
// state that port passes straight through to the RAM.
//
// Ports
//   clk          single clock; all state changes happen on its rising edge
//   reset        asynchronous, active-high reset
//   start        level-sampled request to begin (or restart) a load
//   in_valid     source presents a pixel on in_data
//   in_data      pixel byte
//   in_ready     loader accepts a pixel this cycle; depends on state only
//   cpu_we       processor write enable
//   cpu_address  processor write address
//   cpu_wd       processor write data
//   mem_we       write enable driven into the data RAM
//   mem_address  address driven into the data RAM
//   mem_wd       write data driven into the data RAM
//   busy         high while a load is in progress
//   done         high once a load has completed
//   count        pixels accepted in the current or last load
// -----------------------------------------------------------------------------
module image_loader #(
   parameter int          NUM_PIXELS = 129600,
   parameter logic [31:0] BASE_ADDR  = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        cpu_we,
   input  logic [31:0] cpu_address,
   input  logic [31:0] cpu_wd,
   output logic        mem_we,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wd,
   output logic        busy,
   output logic        done,
   output logic [16:0] count
);

   // The count of the final transfer. Once that transfer is accepted, count
   // reaches NUM_PIXELS and the FSM leaves LOAD, so the counter cannot wrap.
   localparam logic [16:0] LAST_INDEX = 17'(NUM_PIXELS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [16:0] count_reg, count_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         count_reg <= 17'd0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
      end
   end

   always_comb begin
      // Default: hold state. The RAM port belongs to the processor.
      state_next  = state_reg;
      count_next  = count_reg;
      in_ready    = 1'b0;
      mem_we      = cpu_we;
      mem_address = cpu_address;
      mem_wd      = cpu_wd;

      unique case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_LOAD;
               count_next = 17'd0;
            end
         end

         S_LOAD: begin
            // The loader owns the RAM port, so processor writes are dropped.
            // Address and data always present the next pixel slot. Only
            // mem_we qualifies whether a write actually happens.
            in_ready    = 1'b1;
            mem_we      = in_valid;
            mem_address = BASE_ADDR + {15'd0, count_reg};
            mem_wd      = {24'd0, in_data};
            if (in_valid) begin
               count_next = count_reg + 17'd1;
               if (count_reg == LAST_INDEX) begin
                  state_next = S_DONE;
               end
            end
         end

         S_DONE: begin
            if (start) begin
               state_next = S_LOAD;
               count_next = 17'd0;
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Status outputs are decoded from registered state only, so they stay
   // glitch-free.
   assign busy  = (state_reg == S_LOAD);
   assign done  = (state_reg == S_DONE);
   assign count = count_reg;

endmodule
